// File: rtl/fir_pkg.sv
// Shared helpers for the FIR output decimator: pointer sizing and the
// round-half-up / saturate arithmetic used by the datapath and reference models.
package fir_pkg;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_HI   = 2'd1,
        SAT_LO   = 2'd2
    } sat_kind_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Add half an output LSB, then drop SH bits: round half toward +inf.
    function automatic longint round_shift(input longint x, input int sh);
        longint v;
        v = x;
        if (sh > 0) begin
            v = v + (longint'(1) <<< (sh - 1));
        end
        return v >>> sh;
    endfunction

    function automatic sat_kind_t sat_check(input longint x, input int sh, input int ow);
        longint v;
        longint hi;
        longint lo;
        v  = round_shift(x, sh);
        hi = (longint'(1) <<< (ow - 1)) - 1;
        lo = -(longint'(1) <<< (ow - 1));
        if (v > hi) begin
            return SAT_HI;
        end
        if (v < lo) begin
            return SAT_LO;
        end
        return SAT_NONE;
    endfunction

    function automatic longint sat_round(input longint x, input int sh, input int ow);
        longint v;
        v = round_shift(x, sh);
        case (sat_check(x, sh, ow))
            SAT_HI:  v = (longint'(1) <<< (ow - 1)) - 1;
            SAT_LO:  v = -(longint'(1) <<< (ow - 1));
            default: v = v;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is always visible on o_data, and a
// push into a full FIFO is accepted when a pop happens in the same cycle.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = ptr_width(DEPTH);

    // Extra MSB on each pointer separates the full and empty cases.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage is cleared too so the head reads 0 after reset or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_valid = !w_empty;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/fir_out_decim.sv
// Decimates the FirFilter output stream, rounds/saturates kept samples to
// OUTPUT_WIDTH and buffers them behind a ready/valid handshake.
module fir_out_decim
    import fir_pkg::*;
#(
    parameter int INPUT_WIDTH  = 24,
    parameter int OUTPUT_WIDTH = 16,
    parameter int DECIM        = 4,
    parameter int PHASE        = 0,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           valid_in,
    input  logic signed [INPUT_WIDTH-1:0]  din,
    output logic                           valid_out,
    output logic signed [OUTPUT_WIDTH-1:0] dout,
    input  logic                           ready_out,
    output logic                           sat,
    output logic                           overflow
);

    localparam int SH = INPUT_WIDTH - OUTPUT_WIDTH;
    localparam int CW = ptr_width(DECIM);

    generate
        if (OUTPUT_WIDTH > INPUT_WIDTH) begin : g_err_width
            $error("fir_out_decim: OUTPUT_WIDTH must not exceed INPUT_WIDTH");
        end
        if (DECIM < 1 || PHASE < 0 || PHASE >= DECIM) begin : g_err_phase
            $error("fir_out_decim: need DECIM >= 1 and 0 <= PHASE < DECIM");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
            $error("fir_out_decim: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    typedef struct packed {
        logic                           valid;
        logic signed [OUTPUT_WIDTH-1:0] data;
    } stage_t;

    logic [CW-1:0] r_phase;
    stage_t        r_stage;
    logic          r_sat;
    logic          r_ovf;

    logic                           w_keep;
    logic                           w_pop;
    logic                           w_full;
    logic                           w_empty;
    sat_kind_t                      w_kind;
    logic signed [OUTPUT_WIDTH-1:0] w_rounded;

    assign w_keep    = valid_in && (r_phase == CW'(PHASE));
    assign w_kind    = sat_check(longint'(din), SH, OUTPUT_WIDTH);
    assign w_rounded = OUTPUT_WIDTH'(sat_round(longint'(din), SH, OUTPUT_WIDTH));
    assign w_pop     = !w_empty && ready_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_stage <= '0;
            r_sat   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (flush) begin
            r_phase <= '0;
            r_stage <= '0;
            r_sat   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (valid_in) begin
                r_phase <= (r_phase == CW'(DECIM - 1)) ? '0 : r_phase + CW'(1);
            end
            r_stage.valid <= w_keep;
            if (w_keep) begin
                r_stage.data <= w_rounded;
            end
            if (w_keep && (w_kind != SAT_NONE)) begin
                r_sat <= 1'b1;
            end
            // A stage result with nowhere to go is lost; the FIFO keeps its data.
            if (r_stage.valid && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    fir_sync_fifo #(
        .WIDTH (OUTPUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (flush),
        .i_push  (r_stage.valid),
        .i_data  (r_stage.data),
        .i_pop   (w_pop),
        .o_data  (dout),
        .o_valid (valid_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign sat      = r_sat;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_fir_out_decim.sv
// Directed bench for fir_out_decim: instance A runs DECIM=1, instance B runs
// DECIM=4/PHASE=1; both use the default widths and an 8-deep FIFO.
module tb_fir_out_decim;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_flush = 0, a_valid_in = 0, a_ready = 0;
    logic [23:0] a_din = '0;
    logic        a_valid_out, a_sat, a_ovf;
    logic [15:0] a_dout;

    logic        b_flush = 0, b_valid_in = 0, b_ready = 0;
    logic [23:0] b_din = '0;
    logic        b_valid_out, b_sat, b_ovf;
    logic [15:0] b_dout;

    int errors = 0;
    int checks = 0;

    fir_out_decim #(.INPUT_WIDTH(24), .OUTPUT_WIDTH(16), .DECIM(1), .PHASE(0), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .valid_in(a_valid_in), .din(a_din),
        .valid_out(a_valid_out), .dout(a_dout), .ready_out(a_ready), .sat(a_sat), .overflow(a_ovf));

    fir_out_decim #(.INPUT_WIDTH(24), .OUTPUT_WIDTH(16), .DECIM(4), .PHASE(1), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .valid_in(b_valid_in), .din(b_din),
        .valid_out(b_valid_out), .dout(b_dout), .ready_out(b_ready), .sat(b_sat), .overflow(b_ovf));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_a();
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
    endtask

    task automatic flush_b();
        b_flush = 1'b1;
        step();
        b_flush = 1'b0;
    endtask

    task automatic test_reset();
        a_ready = 1'b1;
        b_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (a_valid_out !== 1'b0 || a_dout !== 16'h0000 || a_sat !== 1'b0 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: valid=%b dout=%h sat=%b ovf=%b, expected 0 0000 0 0", a_valid_out, a_dout, a_sat, a_ovf);
        end
        checks++;
        if (b_valid_out !== 1'b0 || b_dout !== 16'h0000 || b_sat !== 1'b0 || b_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: valid=%b dout=%h sat=%b ovf=%b, expected 0 0000 0 0", b_valid_out, b_dout, b_sat, b_ovf);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (a_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: valid=%b expected 0", a_valid_out);
        end
    endtask

    task automatic test_rounding();
        logic [23:0] din_t [3] = '{24'h000180, 24'h00017F, 24'hFFFF80};
        logic [15:0] exp_t [3] = '{16'h0002, 16'h0001, 16'h0000};
        a_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_valid_in = 1'b1;
            a_din = din_t[i];
            step();
            a_valid_in = 1'b0;
            checks++;
            if (a_valid_out !== 1'b0) begin
                errors++;
                $display("FAIL round_latency_%0d: valid one cycle after input=%b expected 0", i, a_valid_out);
            end
            step();
            checks++;
            if (a_valid_out !== 1'b1 || a_dout !== exp_t[i]) begin
                errors++;
                $display("FAIL round_value_%0d: valid=%b dout=%h expected 1 %h", i, a_valid_out, a_dout, exp_t[i]);
            end
            $display("round din=%h dout=%h", din_t[i], a_dout);
            step();
        end
        checks++;
        if (a_sat !== 1'b0) begin
            errors++;
            $display("FAIL round_sat: sat=%b expected 0", a_sat);
        end
    endtask

    task automatic test_saturation();
        flush_a();
        a_ready = 1'b1;
        a_valid_in = 1'b1;
        a_din = 24'h800000;
        step();
        a_valid_in = 1'b0;
        step();
        checks++;
        if (a_valid_out !== 1'b1 || a_dout !== 16'h8000 || a_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_min: valid=%b dout=%h sat=%b expected 1 8000 0", a_valid_out, a_dout, a_sat);
        end
        $display("sat din=800000 dout=%h sat=%b", a_dout, a_sat);
        step();
        a_valid_in = 1'b1;
        a_din = 24'h7FFF80;
        step();
        a_valid_in = 1'b0;
        checks++;
        if (a_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_flag: sat=%b expected 1", a_sat);
        end
        step();
        checks++;
        if (a_valid_out !== 1'b1 || a_dout !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_max: valid=%b dout=%h expected 1 7fff", a_valid_out, a_dout);
        end
        $display("sat din=7fff80 dout=%h sat=%b", a_dout, a_sat);
        step();
        a_valid_in = 1'b1;
        a_din = 24'h000100;
        step();
        a_valid_in = 1'b0;
        step();
        step();
        checks++;
        if (a_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_sticky: sat=%b expected 1", a_sat);
        end
    endtask

    task automatic test_decimation();
        int got [$];
        int k;
        b_ready = 1'b1;
        flush_b();
        for (int c = 0; c < 12; c++) begin
            b_valid_in = (c < 8);
            b_din = (c < 8) ? 24'(c << 8) : 24'h0;
            step();
            if (b_valid_out) begin
                got.push_back(int'(b_dout));
                $display("decim out=%h", b_dout);
            end
        end
        b_valid_in = 1'b0;
        checks++;
        if (got.size() != 2 || (got.size() > 0 && got[0] != 1) || (got.size() > 1 && got[1] != 5)) begin
            errors++;
            $display("FAIL decim_consecutive: count=%0d first=%0d second=%0d expected 2 1 5",
                     got.size(), (got.size() > 0) ? got[0] : -1, (got.size() > 1) ? got[1] : -1);
        end
        got.delete();
        flush_b();
        k = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 16 && (c % 2) == 0) begin
                b_valid_in = 1'b1;
                b_din = 24'((16 + k) << 8);
                k++;
            end else begin
                b_valid_in = 1'b0;
                b_din = 24'h7FFFFF;
            end
            step();
            if (b_valid_out) begin
                got.push_back(int'(b_dout));
                $display("decim_gap out=%h", b_dout);
            end
        end
        b_valid_in = 1'b0;
        checks++;
        if (got.size() != 2 || (got.size() > 0 && got[0] != 17) || (got.size() > 1 && got[1] != 21)) begin
            errors++;
            $display("FAIL decim_gaps: count=%0d first=%0d second=%0d expected 2 17 21",
                     got.size(), (got.size() > 0) ? got[0] : -1, (got.size() > 1) ? got[1] : -1);
        end
    endtask

    task automatic test_backpressure();
        flush_a();
        a_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            a_valid_in = 1'b1;
            a_din = 24'((k + 1) << 8);
            step();
        end
        a_valid_in = 1'b0;
        checks++;
        if (a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_early_ovf: overflow=%b expected 0", a_ovf);
        end
        step();
        checks++;
        if (a_ovf !== 1'b1 || a_valid_out !== 1'b1 || a_dout !== 16'h0001) begin
            errors++;
            $display("FAIL bp_overflow: ovf=%b valid=%b dout=%h expected 1 1 0001", a_ovf, a_valid_out, a_dout);
        end
        for (int s = 0; s < 3; s++) begin
            step();
            checks++;
            if (a_valid_out !== 1'b1 || a_dout !== 16'h0001) begin
                errors++;
                $display("FAIL bp_stall_%0d: valid=%b dout=%h expected 1 0001", s, a_valid_out, a_dout);
            end
        end
        a_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_valid_out !== 1'b1 || a_dout !== 16'(i + 1)) begin
                errors++;
                $display("FAIL bp_drain_%0d: valid=%b dout=%h expected 1 %h", i, a_valid_out, a_dout, 16'(i + 1));
            end
            $display("bp drain dout=%h", a_dout);
            step();
        end
        checks++;
        if (a_valid_out !== 1'b0 || a_ovf !== 1'b1) begin
            errors++;
            $display("FAIL bp_empty: valid=%b ovf=%b expected 0 1", a_valid_out, a_ovf);
        end
    endtask

    task automatic test_full_push_pop();
        flush_a();
        a_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a_valid_in = 1'b1;
            a_din = 24'((10 + k) << 8);
            step();
        end
        a_valid_in = 1'b0;
        step();
        a_valid_in = 1'b1;
        a_din = 24'(18 << 8);
        step();
        a_valid_in = 1'b0;
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        checks++;
        if (a_ovf !== 1'b0 || a_dout !== 16'd11) begin
            errors++;
            $display("FAIL full_pushpop: ovf=%b dout=%h expected 0 000b", a_ovf, a_dout);
        end
        a_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_valid_out !== 1'b1 || a_dout !== 16'(11 + i)) begin
                errors++;
                $display("FAIL full_drain_%0d: valid=%b dout=%h expected 1 %h", i, a_valid_out, a_dout, 16'(11 + i));
            end
            $display("full drain dout=%h", a_dout);
            step();
        end
        checks++;
        if (a_valid_out !== 1'b0 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: valid=%b ovf=%b expected 0 0", a_valid_out, a_ovf);
        end
    endtask

    task automatic fill_five_a();
        a_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a_valid_in = 1'b1;
            a_din = (k == 0) ? 24'h7FFF80 : 24'(k << 8);
            step();
        end
        a_valid_in = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_flush();
        int got [$];
        flush_a();
        fill_five_a();
        checks++;
        if (a_valid_out !== 1'b1 || a_sat !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: valid=%b sat=%b expected 1 1", a_valid_out, a_sat);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_valid_out !== 1'b0 || a_dout !== 16'h0000 || a_sat !== 1'b0 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b dout=%h sat=%b ovf=%b expected 0 0000 0 0", a_valid_out, a_dout, a_sat, a_ovf);
        end
        step();
        rst_n = 1'b1;
        step();
        fill_five_a();
        checks++;
        if (a_valid_out !== 1'b1 || a_sat !== 1'b1) begin
            errors++;
            $display("FAIL pre_flush: valid=%b sat=%b expected 1 1", a_valid_out, a_sat);
        end
        a_flush = 1'b1;
        a_valid_in = 1'b1;
        a_din = 24'h000500;
        #2;
        checks++;
        if (a_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL flush_sync: valid before edge=%b expected 1", a_valid_out);
        end
        step();
        a_flush = 1'b0;
        a_valid_in = 1'b0;
        checks++;
        if (a_valid_out !== 1'b0 || a_dout !== 16'h0000 || a_sat !== 1'b0 || a_ovf !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: valid=%b dout=%h sat=%b ovf=%b expected 0 0000 0 0", a_valid_out, a_dout, a_sat, a_ovf);
        end
        step();
        step();
        checks++;
        if (a_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority: valid=%b expected 0", a_valid_out);
        end
        b_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            b_valid_in = 1'b1;
            b_din = 24'h000300;
            step();
        end
        b_valid_in = 1'b0;
        step();
        step();
        flush_b();
        for (int c = 0; c < 8; c++) begin
            b_valid_in = (c < 4);
            b_din = (c < 4) ? 24'((c + 1) << 8) : 24'h0;
            step();
            if (b_valid_out) begin
                got.push_back(int'(b_dout));
                $display("restart out=%h", b_dout);
            end
        end
        b_valid_in = 1'b0;
        checks++;
        if (got.size() != 1 || (got.size() > 0 && got[0] != 2)) begin
            errors++;
            $display("FAIL restart_phase: count=%0d first=%0d expected 1 2",
                     got.size(), (got.size() > 0) ? got[0] : -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_decimation();
        test_backpressure();
        test_full_push_pop();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
